// File: rtl/mem_pkg.sv
// Shared definitions for the proc2mem/mem2proc memory bus.
// Holds command encodings, bus widths and the tag-advance helper.
// No logic of its own; imported by the responder and its delay line.
package mem_pkg;

  localparam int TAG_W  = 4;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 64;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  // Tags cycle 1..15; zero is reserved for "no tag" on the bus.
  function automatic logic [TAG_W-1:0] tag_next(input logic [TAG_W-1:0] t);
    return (t == 4'd15) ? 4'd1 : t + 4'd1;
  endfunction

endpackage

// File: rtl/mem_delay_line.sv
// Load-return pipeline: carries {valid,tag,data} from acceptance to the bus.
// Latency: exactly LATENCY cycles from i_push to o_tag/o_data.
// No backpressure: one entry per cycle in, one per cycle out, never stalls.
module mem_delay_line
  import mem_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_push,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic [DATA_W-1:0] i_data,
  output logic [TAG_W-1:0]  o_tag,
  output logic [DATA_W-1:0] o_data,
  output logic              o_pop
);

  logic [LATENCY-1:0] r_vld;
  logic [TAG_W-1:0]   r_tag  [LATENCY];
  logic [DATA_W-1:0]  r_data [LATENCY];

  // Shift every stage forward each cycle; reset drops everything in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      r_vld[0]  <= i_push;
      r_tag[0]  <= i_tag;
      r_data[0] <= i_data;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_tag[i]  <= r_tag[i-1];
        r_data[i] <= r_data[i-1];
      end
    end
  end

  // The last stage drives the bus; idle cycles show zero tag and zero data.
  assign o_pop  = r_vld[LATENCY-1];
  assign o_tag  = o_pop ? r_tag[LATENCY-1]  : '0;
  assign o_data = o_pop ? r_data[LATENCY-1] : '0;

endmodule

// File: rtl/mem_responder.sv
// Main-memory responder: accepts one LOAD/STORE per cycle, tags it, returns loads.
// Latency: response tag combinational; load data returned LATENCY cycles later.
// Backpressure: response 0 when the load window is full (or random stall with MEM_RANDOM_STALL_EN).
module mem_responder
  import mem_pkg::*;
#(
  parameter int MEM_DEPTH       = 4096,
  parameter int LATENCY         = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] proc2mem_addr,
  input  logic [1:0]        proc2mem_command,
  input  logic [DATA_W-1:0] proc2mem_data,
  output logic [TAG_W-1:0]  mem2proc_response,
  output logic [TAG_W-1:0]  mem2proc_tag,
  output logic [DATA_W-1:0] mem2proc_data
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  logic [DATA_W-1:0] r_mem [MEM_DEPTH];
  logic [TAG_W-1:0]  r_next_tag;
  logic [3:0]        r_occ;

  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rd_data;
  logic [3:0]        w_occ_eff;
  logic              w_pop;
  logic              w_stall;
  logic              w_load_acc;
  logic              w_store_acc;
  logic              w_acc;
  logic              w_unused;

  // Only the word index matters; upper bits alias and the byte offset is ignored.
  assign w_idx     = proc2mem_addr[3 +: IDX_W];
  assign w_unused  = ^{proc2mem_addr[ADDR_W-1:3+IDX_W], proc2mem_addr[2:0]};
  assign w_rd_data = r_mem[w_idx];

`ifdef MEM_RANDOM_STALL_EN
  logic [7:0] r_lfsr;

  // Free-running LFSR; a 1-in-4 pattern of its low bits forces a retry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_lfsr <= 8'hA5;
    else       r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
  assign w_stall = 1'b0;
`endif

  // A slot returning this cycle is already free for a new load.
  assign w_occ_eff   = r_occ - {3'b000, w_pop};
  assign w_load_acc  = (proc2mem_command == BUS_LOAD) && (w_occ_eff < 4'(MAX_OUTSTANDING)) && !w_stall;
  assign w_store_acc = (proc2mem_command == BUS_STORE) && !w_stall;
  assign w_acc       = w_load_acc || w_store_acc;

  assign mem2proc_response = w_acc ? r_next_tag : '0;

  // Backing store write; contents survive reset.
  always_ff @(posedge clock) begin
    if (w_store_acc && !reset) r_mem[w_idx] <= proc2mem_data;
  end

  // Tag allocator and load-window occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_next_tag <= 4'd1;
      r_occ      <= '0;
    end else begin
      if (w_acc) r_next_tag <= tag_next(r_next_tag);
      r_occ <= r_occ + {3'b000, w_load_acc} - {3'b000, w_pop};
    end
  end

  mem_delay_line #(
    .LATENCY (LATENCY)
  ) u_delay (
    .clock  (clock),
    .reset  (reset),
    .i_push (w_load_acc),
    .i_tag  (r_next_tag),
    .i_data (w_rd_data),
    .o_tag  (mem2proc_tag),
    .o_data (mem2proc_data),
    .o_pop  (w_pop)
  );

endmodule
